prog3_mult_engine: RTL and testbench
====================================

Name: prog3_mult_engine

Overview:
- Hardware responder for program 3 (16 signed 16x16 -> 32-bit multiplications). The bench is the initiator: it drives start and waits for done.
- The engine reads 32 big-endian 2-byte operands from the byte-wide data memory, multiplies each pair sequentially, and writes 16 big-endian 4-byte products back.
- It sits between the start/done handshake and the data-memory port inside the DUT.

Parameters:
- NUM_PAIRS, 16, number of operand pairs / products.
- OPND_BASE, 0, byte address of first operand byte.
- PROD_BASE, 64, byte address of first product byte.
- AW, 8, data-memory address width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from bench; high = hold/arm, high->low launches a run.
- done  out  1  acknowledge; high when all products are written.
- mem_addr  out  AW  byte address to data memory.
- mem_rdata  in  8  read data; combinational (async) read of mem_addr.
- mem_wdata  out  8  write data.
- mem_we  out  1  write enable; memory writes mem_wdata at mem_addr on the rising edge.

Behaviour:
- Reset (async, rst_n low): state=IDLE, armed=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0, pair counter=0.
- Reset mid-run aborts immediately. Memory bytes already written stay; no further writes occur.
- IDLE:
  - Sets armed=1 on any edge where start=1.
  - On an edge with armed=1 and start=0, moves to LOAD with pair j=0.
  - Never launches without first seeing start high.
- LOAD (4 cycles, k=0..3):
  - mem_addr = OPND_BASE+4j+k; latch mem_rdata at the end of each cycle.
  - A = {byte0,byte1} is operand 2j; B = {byte2,byte3} is operand 2j+1.
- MUL (16 cycles): radix-2 Booth, multiplicand B, multiplier A.
  - 33-bit accumulator, one arithmetic-shift step per cycle.
  - Result P = B*A as exact signed 32-bit. All input pairs fit, including -32768*-32768 = 1073741824.
- STORE (4 cycles, k=0..3):
  - mem_we=1, mem_addr = PROD_BASE+4j+k, mem_wdata = P[31-8k -: 8] (MSB byte first).
- NEXT (1 cycle): mem_we=0.
  - If j=NUM_PAIRS-1, go to DONE; otherwise j++ and go to LOAD.
- Latency:
  - Each pair takes exactly 25 cycles.
  - done rises at the edge 16*25 = 400 edges after the edge that sampled the launching start=0.
- DONE:
  - done=1, mem_we=0.
  - On the first edge with start=1, go to IDLE with armed=1 and done=0.
  - If start is already high on DONE entry, done is high for exactly one cycle.
- start toggling during LOAD/MUL/STORE/NEXT is ignored. It does not restart or abort the run.
- mem_we is high only in STORE. There are no reads or writes outside [OPND_BASE, OPND_BASE+4*NUM_PAIRS) and [PROD_BASE, PROD_BASE+4*NUM_PAIRS).
- Operand region is never written; product region is never read.
- Outputs mem_addr/mem_we/mem_wdata/done are registered or decoded from registered state only; no combinational path from start.

Test Plan:
- Reset, start=1 for 2 cycles, then 0; pair0 = 3,7 (mem[0..3]=00 03 00 07) -> mem[64..67]=00 00 00 15, done exactly 400 edges after launch.
- Corner pairs: (-32768,-32768) -> 40 00 00 00; (-1,1) -> FF FF FF FF; (32767,-32768) -> C0 00 80 00; (0,-5) -> 00 00 00 00; all 16 slots checked against the signed golden model.
- 10 back-to-back random runs, each cycle start 1->0, wait done, start 1->0 -> all 16 products match every run; done clears on the edge after start=1.
- Assert rst_n low during STORE of pair 5 -> done=0, mem_we=0 immediately; products 0-4 intact, no further writes; the next start 1->0 after re-arm completes correctly.
- Hold start=0 continuously from reset -> engine stays IDLE, no memory access, done=0. Pulse start high mid-run -> run is unaffected, done still at edge 400.
- Monitor every cycle -> mem_we never asserted with an address outside 64..127; no operand byte modified.

Source files
------------

// File: rtl/prog3_mult_engine_if.sv
// Start/done handshake and byte-wide data-memory port of the program-3 multiply engine.
// The engine takes the slave side; the initiator/memory owner takes the master side.
interface prog3_mult_engine_if #(
  parameter int AW = 8
);
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [7:0]    mem_wdata;
  logic          mem_we;

  modport master (
    output start, mem_rdata,
    input  done, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  start, mem_rdata,
    output done, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/prog3_mult_engine.sv
// Program-3 engine: loads 16 signed 16-bit operand pairs, radix-2 Booth multiplies each pair,
// and stores the 32-bit products big-endian; 25 cycles per pair, launched by start falling.
module prog3_mult_engine #(
  parameter int NUM_PAIRS = 16,
  parameter int OPND_BASE = 0,
  parameter int PROD_BASE = 64,
  parameter int AW        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog3_mult_engine_if.slave   bus
);

  localparam int JW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          r_armed;
  logic [JW-1:0] r_j;
  logic [3:0]    r_k;
  logic [23:0]   r_ab;      // last three operand bytes; B lives in [15:0] during MUL
  logic [32:0]   r_acc;     // {17-bit Booth high half, 16-bit multiplier/low half}
  logic          r_q1;
  logic [23:0]   w_ab_next;
  logic [16:0]   w_mcand;
  logic [16:0]   w_sum;
  logic          w_last_j;

  assign w_ab_next = {r_ab[15:0], bus.mem_rdata};
  assign w_mcand   = {r_ab[15], r_ab[15:0]};
  assign w_last_j  = (r_j == JW'(NUM_PAIRS - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; start only matters in IDLE and DONE.
  // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (r_armed && !bus.start) w_state_next = S_LOAD;
      S_LOAD:  if (r_k == 4'd3)           w_state_next = S_MUL;
      S_MUL:   if (r_k == 4'd15)          w_state_next = S_STORE;
      S_STORE: if (r_k == 4'd3)           w_state_next = S_NEXT;
      S_NEXT:  w_state_next = w_last_j ? S_DONE : S_LOAD;
      S_DONE:  if (bus.start)             w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.done      = 1'b0;
    unique case (r_state)
      S_LOAD: bus.mem_addr = AW'(OPND_BASE + 4 * int'(r_j) + int'(r_k));
      S_STORE: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = AW'(PROD_BASE + 4 * int'(r_j) + int'(r_k));
        unique case (r_k[1:0])
          2'd0:    bus.mem_wdata = r_acc[31:24];
          2'd1:    bus.mem_wdata = r_acc[23:16];
          2'd2:    bus.mem_wdata = r_acc[15:8];
          default: bus.mem_wdata = r_acc[7:0];
        endcase
      end
      S_DONE:  bus.done = 1'b1;
      default: ;
    endcase
  end

  // Booth add/subtract selected by the current multiplier bit and the bit shifted out last.
  always_comb begin
    w_sum = r_acc[32:16];
    unique case ({r_acc[0], r_q1})
      2'b01:   w_sum = r_acc[32:16] + w_mcand;
      2'b10:   w_sum = r_acc[32:16] - w_mcand;
      default: w_sum = r_acc[32:16];
    endcase
  end

  // Arming: any sampled start=1 in IDLE or DONE arms; the first start=0 while armed launches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_armed <= 1'b0;
    else        r_armed <= bus.start && (r_state == S_IDLE || r_state == S_DONE);
  end

  // Counters and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_j   <= '0;
      r_k   <= '0;
      r_ab  <= '0;
      r_acc <= '0;
      r_q1  <= 1'b0;
    end else begin
      if (w_state_next != r_state)                       r_k <= '0;
      else if (r_state inside {S_LOAD, S_MUL, S_STORE})  r_k <= r_k + 4'd1;

      if (r_state == S_IDLE)                 r_j <= '0;
      else if (r_state == S_NEXT && !w_last_j) r_j <= r_j + JW'(1);

      unique case (r_state)
        S_LOAD: begin
          r_ab <= w_ab_next;
          if (r_k == 4'd3) begin
            r_acc <= {17'd0, r_ab[23:8]};
            r_q1  <= 1'b0;
          end
        end
        S_MUL: begin
          r_acc <= {w_sum[16], w_sum, r_acc[15:1]};
          r_q1  <= r_acc[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog3_mult_engine.sv
// Scoreboard bench for prog3_mult_engine: the stimulus queues expected product writes, and a
// negedge monitor pops and compares every memory write the engine issues.
module tb_prog3_mult_engine;

  localparam int NUM_PAIRS = 16;
  localparam int PROD_BASE = 64;

  // {A, B, A*B} hand-computed.
  localparam logic [63:0] DIR [16] = '{
    {16'h0003, 16'h0007, 32'h0000_0015},
    {16'h8000, 16'h8000, 32'h4000_0000},
    {16'hFFFF, 16'h0001, 32'hFFFF_FFFF},
    {16'h7FFF, 16'h8000, 32'hC000_8000},
    {16'h0000, 16'hFFFB, 32'h0000_0000},
    {16'h7FFF, 16'h7FFF, 32'h3FFF_0001},
    {16'h8000, 16'h0001, 32'hFFFF_8000},
    {16'h0001, 16'h8000, 32'hFFFF_8000},
    {16'h8000, 16'h7FFF, 32'hC000_8000},
    {16'h0100, 16'h0100, 32'h0001_0000},
    {16'hFFFE, 16'hFFFD, 32'h0000_0006},
    {16'h0064, 16'hFF9C, 32'hFFFF_D8F0},
    {16'h1234, 16'h0002, 32'h0000_2468},
    {16'hFFFF, 16'hFFFF, 32'h0000_0001},
    {16'h3039, 16'hFFFF, 32'hFFFF_CFC7},
    {16'h03E8, 16'h03E8, 32'h000F_4240}
  };

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog3_mult_engine_if #(.AW(8)) bus ();

  prog3_mult_engine #(
    .NUM_PAIRS(NUM_PAIRS), .OPND_BASE(0), .PROD_BASE(PROD_BASE), .AW(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte memory with combinational read; the bench preloads it through a side write port.
  logic [7:0] mem [0:255];
  logic       ld_we = 1'b0;
  logic [7:0] ld_addr = 8'd0;
  logic [7:0] ld_data = 8'd0;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (ld_we)      mem[ld_addr]      <= ld_data;
  end

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_q [$];
  logic [7:0]  op_img   [0:63];
  logic [31:0] exp_prod [0:15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must be in the product region and match the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && bus.mem_we) begin
      check("wr_in_product_range", (bus.mem_addr >= 8'd64 && bus.mem_addr < 8'd128), 1);
      if (exp_q.size() == 0) begin
        check("wr_was_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic tb_write(input logic [7:0] addr, input logic [7:0] data);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1;
    ld_we   = 1'b0;
  endtask

  task automatic clear_products();
    for (int i = 0; i < 64; i++) tb_write(8'(PROD_BASE + i), 8'hAA);
  endtask

  task automatic load_pairs(input bit rnd);
    logic [63:0]        v;
    logic [15:0]        a, b;
    logic signed [31:0] p;
    for (int j = 0; j < NUM_PAIRS; j++) begin
      if (rnd) begin
        a = 16'($urandom);
        b = 16'($urandom);
        p = 32'($signed(a)) * 32'($signed(b));
      end else begin
        v = DIR[j];
        a = v[63:48];
        b = v[47:32];
        p = v[31:0];
      end
      exp_prod[j]     = p;
      op_img[4*j]     = a[15:8];
      op_img[4*j + 1] = a[7:0];
      op_img[4*j + 2] = b[15:8];
      op_img[4*j + 3] = b[7:0];
      for (int k = 0; k < 4; k++) tb_write(8'(4*j + k), op_img[4*j + k]);
    end
    clear_products();
  endtask

  task automatic push_expected();
    wr_t e;
    for (int j = 0; j < NUM_PAIRS; j++)
      for (int k = 0; k < 4; k++) begin
        e.addr = 8'(PROD_BASE + 4*j + k);
        e.data = exp_prod[j][31 - 8*k -: 8];
        exp_q.push_back(e);
      end
  endtask

  task automatic check_products(input int n_good);
    int bad;
    for (int j = 0; j < n_good; j++)
      check($sformatf("product_%0d", j),
            {mem[PROD_BASE + 4*j], mem[PROD_BASE + 4*j + 1],
             mem[PROD_BASE + 4*j + 2], mem[PROD_BASE + 4*j + 3]}, exp_prod[j]);
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== op_img[i]) bad++;
    check("operands_intact", bad, 0);
  endtask

  // start 1 for two edges, then 0; returns right after the launching edge.
  task automatic launch();
    logic prev_done;
    prev_done = bus.done;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (prev_done) check("done_clears_after_start", bus.done, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_once(input bit pulse_mid, input bit early_start);
    int   n;
    logic seen;
    push_expected();
    launch();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 600) begin
      @(posedge clk);
      n++;
      #1;
      if (pulse_mid && n == 200) bus.start = 1'b1;
      if (pulse_mid && n == 203) bus.start = 1'b0;
      if (early_start && n == 390) bus.start = 1'b1;
      seen = bus.done;
    end
    check("done_latency_edges", n, 400);
    check("writes_drained", exp_q.size(), 0);
    if (early_start) begin
      @(posedge clk);
      #1;
      check("done_single_cycle", bus.done, 0);
    end else begin
      repeat (3) @(posedge clk);
      #1;
      check("done_holds", bus.done, 1);
    end
    check_products(NUM_PAIRS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         bad;
    logic [7:0] snap [0:63];

    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", bus.done, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    rst_n = 1'b1;

    // Never armed: must stay quiet.
    bad = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.mem_we || bus.done || bus.mem_addr != 8'd0) bad++;
    end
    check("idle_without_start", bad, 0);

    load_pairs(1'b0);
    run_once(1'b1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      load_pairs(1'b1);
      run_once(1'b0, r == 9);
    end

    // Abort during STORE of pair 5 (first byte already written).
    load_pairs(1'b0);
    push_expected();
    launch();
    repeat (146) @(posedge clk);
    #1;
    check("abort_in_store", bus.mem_we, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_done", bus.done, 0);
    check("abort_we", bus.mem_we, 0);
    check("abort_addr", bus.mem_addr, 0);
    check_products(5);
    check("abort_pair5_byte0", mem[PROD_BASE + 20], exp_prod[5][31:24]);
    check("abort_pair5_byte1", mem[PROD_BASE + 21], 8'hAA);
    for (int i = 0; i < 64; i++) snap[i] = mem[PROD_BASE + i];
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[PROD_BASE + i] !== snap[i]) bad++;
    check("no_writes_after_abort", bad, 0);
    check("idle_after_abort", bus.done, 0);

    clear_products();
    run_once(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
